// File: rtl/dscr_frame_ctrl_pkg.sv
// Shared types and defaults for the descrambler frame controller.
// Used by dscr_frame_ctrl and dscr_stats.
package dscr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HEADER  = 2'd2
    } state_t;

    localparam logic [17:0] DSCR_SEED_X_DEF = 18'h00001;
    localparam logic [17:0] DSCR_SEED_Y_DEF = 18'h3FFFF;
    localparam logic [15:0] DSCR_HDR_DEF    = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dscr_frame_ctrl_stats.sv
// Saturating good/bad header counters; built only when DSCR_FRAME_STATS_EN is defined.
// Counters clear on reset only.
module dscr_stats
    import dscr_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_good,
    input  logic        i_bad,
    output logic [15:0] o_frames,
    output logic [15:0] o_misses
);

    logic [15:0] r_frames;
    logic [15:0] r_misses;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frames <= '0;
            r_misses <= '0;
        end else begin
            if (i_good) r_frames <= sat_inc16(r_frames);
            if (i_bad)  r_misses <= sat_inc16(r_misses);
        end
    end

    assign o_frames = r_frames;
    assign o_misses = r_misses;

endmodule

// File: rtl/dscr_frame_ctrl.sv
// Frame sequencer for the PL descrambler: header hunt, flywheel lock, payload stepping
// and seed loading. Optional statistics are enabled by the macro DSCR_FRAME_STATS_EN.
module dscr_frame_ctrl
    import dscr_ctrl_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] HDR_PATTERN = DATA_W'(DSCR_HDR_DEF),
    parameter int                HDR_WORDS   = 4,
    parameter int                FRAME_LEN   = 1024,
    parameter int                LEN_W       = 11,
    parameter int                LOCK_MISS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic [17:0]       cfg_seed_x,
    input  logic [17:0]       cfg_seed_y,
    input  logic              cfg_update,
    output logic [DATA_W-1:0] out_data,
    output logic              dsc_step,
    output logic              dsc_load,
    output logic [17:0]       seed_x,
    output logic [17:0]       seed_y,
    output logic              frame_start,
    output logic              frame_end,
    output logic              locked,
    output logic              lock_lost,
    output logic [15:0]       stat_frames,
    output logic [15:0]       stat_misses,
    output logic [1:0]        dbg_state
);

    localparam int HDR_W  = $clog2(HDR_WORDS + 1);
    localparam int MISS_W = $clog2(LOCK_MISS + 1);
    localparam logic [HDR_W-1:0]  HDR_LAST  = HDR_W'(HDR_WORDS - 1);
    localparam logic [LEN_W-1:0]  LEN_LAST  = LEN_W'(FRAME_LEN - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOCK_MISS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HDR_W-1:0]    r_hdr_cnt,  w_hdr_cnt_nxt;
    logic                r_hdr_bad,  w_hdr_bad_nxt;
    logic [LEN_W-1:0]    r_pay_cnt,  w_pay_cnt_nxt;
    logic [MISS_W-1:0]   r_miss_cnt, w_miss_nxt;
    logic                r_locked,   w_locked_nxt;
    logic                w_step_nxt, w_load_nxt, w_fe_nxt, w_lost_nxt;
    logic                w_good_hdr, w_bad_hdr;
    logic                w_match, w_bad_any;

    logic [DATA_W-1:0]   r_out_data;
    logic                r_step, r_load, r_fe, r_lost;
    logic [17:0]         r_shadow_x, r_shadow_y;
    logic [17:0]         r_seed_x,   r_seed_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_HUNT;
        else        r_state <= w_state_nxt;
    end

    assign w_match   = (in_data == HDR_PATTERN);
    assign w_bad_any = r_hdr_bad | ~w_match;

    always_comb begin
        w_state_nxt   = r_state;
        w_hdr_cnt_nxt = r_hdr_cnt;
        w_hdr_bad_nxt = r_hdr_bad;
        w_pay_cnt_nxt = r_pay_cnt;
        w_miss_nxt    = r_miss_cnt;
        w_locked_nxt  = r_locked;
        w_step_nxt    = 1'b0;
        w_load_nxt    = 1'b0;
        w_fe_nxt      = 1'b0;
        w_lost_nxt    = 1'b0;
        w_good_hdr    = 1'b0;
        w_bad_hdr     = 1'b0;
        if (in_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (!w_match) begin
                        w_hdr_cnt_nxt = '0;
                    end else if (r_hdr_cnt == HDR_LAST) begin
                        w_hdr_cnt_nxt = '0;
                        w_locked_nxt  = 1'b1;
                        w_load_nxt    = 1'b1;
                        w_miss_nxt    = '0;
                        w_good_hdr    = 1'b1;
                        w_state_nxt   = ST_PAYLOAD;
                    end else begin
                        w_hdr_cnt_nxt = r_hdr_cnt + 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    // Header-looking words here are ordinary data.
                    w_step_nxt = 1'b1;
                    if (r_pay_cnt == LEN_LAST) begin
                        w_fe_nxt      = 1'b1;
                        w_pay_cnt_nxt = '0;
                        w_hdr_cnt_nxt = '0;
                        w_hdr_bad_nxt = 1'b0;
                        w_state_nxt   = ST_HEADER;
                    end else begin
                        w_pay_cnt_nxt = r_pay_cnt + 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (r_hdr_cnt != HDR_LAST) begin
                        w_hdr_cnt_nxt = r_hdr_cnt + 1'b1;
                        w_hdr_bad_nxt = w_bad_any;
                    end else begin
                        w_hdr_cnt_nxt = '0;
                        w_hdr_bad_nxt = 1'b0;
                        if (!w_bad_any) begin
                            w_miss_nxt  = '0;
                            w_load_nxt  = 1'b1;
                            w_good_hdr  = 1'b1;
                            w_state_nxt = ST_PAYLOAD;
                        end else if (r_miss_cnt == MISS_LAST) begin
                            w_miss_nxt   = '0;
                            w_locked_nxt = 1'b0;
                            w_lost_nxt   = 1'b1;
                            w_bad_hdr    = 1'b1;
                            w_state_nxt  = ST_HUNT;
                        end else begin
                            // Flywheel: keep lock and start the frame anyway.
                            w_miss_nxt  = r_miss_cnt + 1'b1;
                            w_load_nxt  = 1'b1;
                            w_bad_hdr   = 1'b1;
                            w_state_nxt = ST_PAYLOAD;
                        end
                    end
                end
                default: begin
                    w_state_nxt   = ST_HUNT;
                    w_hdr_cnt_nxt = '0;
                    w_pay_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hdr_cnt  <= '0;
            r_hdr_bad  <= 1'b0;
            r_pay_cnt  <= '0;
            r_miss_cnt <= '0;
            r_locked   <= 1'b0;
            r_step     <= 1'b0;
            r_load     <= 1'b0;
            r_fe       <= 1'b0;
            r_lost     <= 1'b0;
            r_out_data <= '0;
            r_shadow_x <= DSCR_SEED_X_DEF;
            r_shadow_y <= DSCR_SEED_Y_DEF;
            r_seed_x   <= DSCR_SEED_X_DEF;
            r_seed_y   <= DSCR_SEED_Y_DEF;
        end else begin
            r_hdr_cnt  <= w_hdr_cnt_nxt;
            r_hdr_bad  <= w_hdr_bad_nxt;
            r_pay_cnt  <= w_pay_cnt_nxt;
            r_miss_cnt <= w_miss_nxt;
            r_locked   <= w_locked_nxt;
            r_step     <= w_step_nxt;
            r_load     <= w_load_nxt;
            r_fe       <= w_fe_nxt;
            r_lost     <= w_lost_nxt;
            if (in_valid)   r_out_data <= in_data;
            if (cfg_update) begin
                r_shadow_x <= cfg_seed_x;
                r_shadow_y <= cfg_seed_y;
            end
            // Loads sample the shadow before any same-edge cfg_update lands.
            if (w_load_nxt) begin
                r_seed_x <= r_shadow_x;
                r_seed_y <= r_shadow_y;
            end
        end
    end

    assign out_data    = r_out_data;
    assign dsc_step    = r_step;
    assign dsc_load    = r_load;
    assign frame_start = r_load;
    assign frame_end   = r_fe;
    assign locked      = r_locked;
    assign lock_lost   = r_lost;
    assign seed_x      = r_seed_x;
    assign seed_y      = r_seed_y;
    assign dbg_state   = r_state;

`ifdef DSCR_FRAME_STATS_EN
    dscr_stats u_stats (
        .clk      (clk),
        .reset    (reset),
        .i_good   (w_good_hdr),
        .i_bad    (w_bad_hdr),
        .o_frames (stat_frames),
        .o_misses (stat_misses)
    );
`else
    logic w_unused_stats;
    assign w_unused_stats = w_good_hdr ^ w_bad_hdr;
    assign stat_frames    = '0;
    assign stat_misses    = '0;
`endif

endmodule

// File: tb/tb_dscr_frame_ctrl.sv
// Directed table-driven bench for dscr_frame_ctrl (FRAME_LEN=8, LOCK_MISS=2),
// plus hand-written sequences for asynchronous reset and reacquisition.
module tb_dscr_frame_ctrl;

    localparam logic [17:0] SX0 = 18'h00001;
    localparam logic [17:0] SY0 = 18'h3FFFF;
    localparam logic [17:0] SX1 = 18'h2AAAA;
    localparam logic [17:0] SY1 = 18'h15555;
    // Flag order: {step, load, frame_start, frame_end, locked, lock_lost}
    localparam logic [5:0] F_0    = 6'b000000;
    localparam logic [5:0] F_L    = 6'b000010;
    localparam logic [5:0] F_LOAD = 6'b011010;
    localparam logic [5:0] F_STEP = 6'b100010;
    localparam logic [5:0] F_FE   = 6'b100110;
    localparam logic [5:0] F_LOST = 6'b000001;
    localparam logic [1:0] S_HUNT = 2'd0;
    localparam logic [1:0] S_PAY  = 2'd1;
    localparam logic [1:0] S_HDR  = 2'd2;
`ifdef DSCR_FRAME_STATS_EN
    localparam logic [15:0] EXP_FRAMES = 16'd5;
    localparam logic [15:0] EXP_MISSES = 16'd3;
    localparam logic [15:0] EXP_FRAMES_RE = 16'd1;
`else
    localparam logic [15:0] EXP_FRAMES = 16'd0;
    localparam logic [15:0] EXP_MISSES = 16'd0;
    localparam logic [15:0] EXP_FRAMES_RE = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic [17:0] cfg_seed_x, cfg_seed_y;
    logic        cfg_update;
    logic [15:0] out_data;
    logic        dsc_step, dsc_load, frame_start, frame_end, locked, lock_lost;
    logic [17:0] seed_x, seed_y;
    logic [15:0] stat_frames, stat_misses;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dscr_frame_ctrl #(
        .DATA_W(16), .HDR_PATTERN(16'hFFFF), .HDR_WORDS(4),
        .FRAME_LEN(8), .LEN_W(4), .LOCK_MISS(2)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .cfg_seed_x(cfg_seed_x), .cfg_seed_y(cfg_seed_y), .cfg_update(cfg_update),
        .out_data(out_data), .dsc_step(dsc_step), .dsc_load(dsc_load),
        .seed_x(seed_x), .seed_y(seed_y), .frame_start(frame_start),
        .frame_end(frame_end), .locked(locked), .lock_lost(lock_lost),
        .stat_frames(stat_frames), .stat_misses(stat_misses), .dbg_state(dbg_state)
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        upd;
        logic [15:0] e_out;
        logic [5:0]  e_flg;
        logic [1:0]  e_st;
        logic [17:0] e_sx;
        logic [17:0] e_sy;
    } vec_t;

    vec_t        tbl[$];
    logic [17:0] ex_sx, ex_sy;

    function automatic logic [5:0] flags();
        return {dsc_step, dsc_load, frame_start, frame_end, locked, lock_lost};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [15:0] d, input logic upd,
                       input logic [15:0] eo, input logic [5:0] f, input logic [1:0] st);
        vec_t t;
        t.v = v; t.d = d; t.upd = upd; t.e_out = eo; t.e_flg = f; t.e_st = st;
        t.e_sx = ex_sx; t.e_sy = ex_sy;
        tbl.push_back(t);
    endtask

    task automatic add_pay(input logic [15:0] base);
        for (int i = 1; i <= 7; i++) add(1'b1, base + 16'(i), 1'b0, base + 16'(i), F_STEP, S_PAY);
        add(1'b1, base + 16'd8, 1'b0, base + 16'd8, F_FE, S_HDR);
    endtask

    task automatic add_hdr(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input logic [5:0] fl, input logic [1:0] st,
                           input logic upd, input logic [17:0] sx, input logic [17:0] sy);
        add(1'b1, w0, 1'b0, w0, F_L, S_HDR);
        add(1'b1, w1, 1'b0, w1, F_L, S_HDR);
        add(1'b1, w2, 1'b0, w2, F_L, S_HDR);
        ex_sx = sx; ex_sy = sy;
        add(1'b1, w3, upd, w3, fl, st);
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        in_valid = v; in_data = d; cfg_update = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; cfg_update = 1'b0;
        cfg_seed_x = SX1; cfg_seed_y = SY1;
        ex_sx = SX0; ex_sy = SY0;

        // Acquisition: a broken run, then a full header run.
        for (int i = 0; i < 3; i++) add(1'b1, 16'hFFFF, 1'b0, 16'hFFFF, F_0, S_HUNT);
        add(1'b1, 16'h1234, 1'b0, 16'h1234, F_0, S_HUNT);
        for (int i = 0; i < 3; i++) add(1'b1, 16'hFFFF, 1'b0, 16'hFFFF, F_0, S_HUNT);
        add(1'b1, 16'hFFFF, 1'b0, 16'hFFFF, F_LOAD, S_PAY);
        add_pay(16'h0000);
        add_hdr(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, F_LOAD, S_PAY, 1'b0, SX0, SY0);
        add_pay(16'h0010);
        add_hdr(16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, F_LOAD, S_PAY, 1'b0, SX0, SY0);
        add_pay(16'h0020);
        // cfg_update on the 4th header word: this load still uses the old shadow.
        add_hdr(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, F_LOAD, S_PAY, 1'b1, SX0, SY0);
        for (int i = 1; i <= 3; i++) add(1'b1, 16'h0030 + 16'(i), 1'b0, 16'h0030 + 16'(i), F_STEP, S_PAY);
        for (int i = 0; i < 3; i++) add(1'b0, 16'h0BAD, 1'b0, 16'h0033, F_L, S_PAY);
        for (int i = 4; i <= 7; i++) add(1'b1, 16'h0030 + 16'(i), 1'b0, 16'h0030 + 16'(i), F_STEP, S_PAY);
        add(1'b1, 16'h0038, 1'b0, 16'h0038, F_FE, S_HDR);
        add_hdr(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, F_LOAD, S_PAY, 1'b0, SX1, SY1);
        add_pay(16'h0040);
        add_hdr(16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, F_LOAD, S_PAY, 1'b0, SX1, SY1);
        add_pay(16'h0050);
        add_hdr(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, F_LOST, S_HUNT, 1'b0, SX1, SY1);
        // Reacquire with a 5-word run: the 5th FFFF is payload word 0.
        for (int i = 0; i < 3; i++) add(1'b1, 16'hFFFF, 1'b0, 16'hFFFF, F_0, S_HUNT);
        add(1'b1, 16'hFFFF, 1'b0, 16'hFFFF, F_LOAD, S_PAY);
        add(1'b1, 16'hFFFF, 1'b0, 16'hFFFF, F_STEP, S_PAY);
        for (int i = 1; i <= 6; i++) add(1'b1, 16'h0060 + 16'(i), 1'b0, 16'h0060 + 16'(i), F_STEP, S_PAY);
        add(1'b1, 16'h0067, 1'b0, 16'h0067, F_FE, S_HDR);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", -1, 32'(out_data), 32'h0);
        chk("rst_flags", -1, 32'(flags()), 32'(F_0));
        chk("rst_seed_x", -1, 32'(seed_x), 32'(SX0));
        chk("rst_seed_y", -1, 32'(seed_y), 32'(SY0));
        chk("rst_state", -1, 32'(dbg_state), 32'(S_HUNT));
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; cfg_update = tbl[i].upd;
            @(posedge clk); #1;
            cfg_update = 1'b0;
            chk("out_data", i, 32'(out_data), 32'(tbl[i].e_out));
            chk("flags", i, 32'(flags()), 32'(tbl[i].e_flg));
            chk("state", i, 32'(dbg_state), 32'(tbl[i].e_st));
            chk("seed_x", i, 32'(seed_x), 32'(tbl[i].e_sx));
            chk("seed_y", i, 32'(seed_y), 32'(tbl[i].e_sy));
        end
        chk("stat_frames", -2, 32'(stat_frames), 32'(EXP_FRAMES));
        chk("stat_misses", -2, 32'(stat_misses), 32'(EXP_MISSES));

        // Good header, a few payload words, then reset mid-frame between edges.
        for (int i = 0; i < 4; i++) drive(1'b1, 16'hFFFF);
        chk("pre_rst_load", -3, 32'(flags()), 32'(F_LOAD));
        for (int i = 1; i <= 3; i++) drive(1'b1, 16'h0070 + 16'(i));
        chk("pre_rst_step", -3, 32'(flags()), 32'(F_STEP));
        #3 reset = 1'b0;
        #1;
        chk("async_out", -4, 32'(out_data), 32'h0);
        chk("async_flags", -4, 32'(flags()), 32'(F_0));
        chk("async_seed_x", -4, 32'(seed_x), 32'(SX0));
        chk("async_seed_y", -4, 32'(seed_y), 32'(SY0));
        chk("async_state", -4, 32'(dbg_state), 32'(S_HUNT));
        chk("async_frames", -4, 32'(stat_frames), 32'h0);
        chk("async_misses", -4, 32'(stat_misses), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'hFFFF);
            chk("reacq_wait", i, 32'(flags()), 32'(F_0));
        end
        drive(1'b1, 16'hFFFF);
        chk("reacq_flags", -5, 32'(flags()), 32'(F_LOAD));
        chk("reacq_seed_x", -5, 32'(seed_x), 32'(SX0));
        chk("reacq_seed_y", -5, 32'(seed_y), 32'(SY0));
        chk("reacq_state", -5, 32'(dbg_state), 32'(S_PAY));
        chk("reacq_frames", -5, 32'(stat_frames), 32'(EXP_FRAMES_RE));
        drive(1'b0, 16'h0000);
        chk("idle_flags", -6, 32'(flags()), 32'(F_L));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
